// File: rtl/data_bus_uart_tx.sv
// data_bus_uart_tx
//   Memory-mapped 8N1 UART transmitter on the CPU data-memory port.
//   Bytes stored to TXDATA are queued in a small FIFO and shifted out LSB
//   first on oTx, which idles high.
//
// Register map (word offset from iData_Addr[3:2]):
//   0x0 TXDATA   W : push iData_WrData[7:0]; reads 0
//   0x4 STATUS   R : {count[8:4], overflow[3], empty[2], full[1], busy[0]}
//                W : 1 in bit3 clears overflow
//   0x8 BAUD_DIV RW: bits[15:0], clocks per bit, values below 2 stored as 2
//   0xC          reads 0, writes ignored
//
// Ports:
//   iClk, iRst     clock and asynchronous active-high reset
//   iSel           block select from the address decoder
//   iFunct3        store size (SB/SH/SW)
//   iData_WrEn     store strobe
//   iData_Addr     byte address
//   iData_WrData   store data
//   oData_RdData   combinational read data, 0 when iSel is low
//   oTx            registered serial output
module data_bus_uart_tx #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iSel,
    input  logic [2:0]  iFunct3,
    input  logic        iData_WrEn,
    input  logic [31:0] iData_Addr,
    input  logic [31:0] iData_WrData,
    output logic [31:0] oData_RdData,
    output logic        oTx
);

    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned RST_DIV_RAW = CLK_FREQ / BAUD;
    localparam logic [15:0] RST_DIV     = (RST_DIV_RAW < 2) ? 16'd2 : 16'(RST_DIV_RAW);
    localparam logic [4:0]  DEPTH_C     = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         baud_cnt_q, baud_cnt_d;
    logic [15:0]         div_act_q, div_act_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [4:0]          count_q, count_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         baud_div_q, baud_div_d;
    logic [7:0]          mem [FIFO_DEPTH];

    logic                wr_en, wr_tx, wr_stat, wr_baud;
    logic                fifo_empty, fifo_full, busy;
    logic                pop, push, bit_done;
    logic [15:0]         baud_merged;
    logic                unused_bits;

    assign unused_bits = ^{iData_Addr[31:4], iData_WrData[31:16], iFunct3[2]};

    // ------------------------------------------------------------------
    // Bus write decode
    // ------------------------------------------------------------------
    assign wr_en   = iSel & iData_WrEn;
    assign wr_tx   = wr_en && (iData_Addr[3:2] == 2'd0);
    assign wr_stat = wr_en && (iData_Addr[3:2] == 2'd1);
    assign wr_baud = wr_en && (iData_Addr[3:2] == 2'd2);

    assign fifo_empty = (count_q == 5'd0);
    assign fifo_full  = (count_q == DEPTH_C);
    assign busy       = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    assign bit_done = (baud_cnt_q == (div_act_q - 16'd1));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        div_act_d  = div_act_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = mem[rptr_q];
                    div_act_d  = baud_div_q;
                    bit_cnt_d  = 3'd0;
                    baud_cnt_d = 16'd0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    baud_cnt_d = 16'd0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem[rptr_q];
                        div_act_d = baud_div_q;
                        bit_cnt_d = 3'd0;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so oTx stays registered.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and status
    // ------------------------------------------------------------------
    // A full FIFO still accepts a push when the FSM frees a slot this edge.
    assign push = wr_tx && (!fifo_full || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        wptr_d = push ? (wptr_q + 1'b1) : wptr_q;
        rptr_d = pop  ? (rptr_q + 1'b1) : rptr_q;

        ovf_d = ovf_q;
        if (wr_stat && iData_WrData[3]) begin
            ovf_d = 1'b0;
        end
        if (wr_tx && !push) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // BAUD_DIV write with byte/halfword lane selection
    // ------------------------------------------------------------------
    always_comb begin
        baud_merged = baud_div_q;
        case (iFunct3[1:0])
            2'b00: begin
                case (iData_Addr[1:0])
                    2'd0:    baud_merged[7:0]  = iData_WrData[7:0];
                    2'd1:    baud_merged[15:8] = iData_WrData[7:0];
                    default: baud_merged = baud_div_q;
                endcase
            end
            2'b01: begin
                if (!iData_Addr[1]) begin
                    baud_merged = iData_WrData[15:0];
                end
            end
            default: baud_merged = iData_WrData[15:0];
        endcase

        baud_div_d = baud_div_q;
        if (wr_baud) begin
            baud_div_d = (baud_merged < 16'd2) ? 16'd2 : baud_merged;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        oData_RdData = '0;
        if (iSel) begin
            case (iData_Addr[3:2])
                2'd1:    oData_RdData = {23'd0, count_q, ovf_q, fifo_empty, fifo_full, busy};
                2'd2:    oData_RdData = {16'd0, baud_div_q};
                default: oData_RdData = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            div_act_q  <= RST_DIV;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            ovf_q      <= 1'b0;
            baud_div_q <= RST_DIV;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_act_q  <= div_act_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            ovf_q      <= ovf_d;
            baud_div_q <= baud_div_d;
        end
    end

    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wptr_q] <= iData_WrData[7:0];
        end
    end

    assign oTx = tx_q;

endmodule

// File: tb/tb_data_bus_uart_tx.sv
module tb_data_bus_uart_tx;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned RST_DIV = 10;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iSel = 1'b0;
    logic [2:0]  iFunct3 = 3'd0;
    logic        iData_WrEn = 1'b0;
    logic [31:0] iData_Addr = '0;
    logic [31:0] iData_WrData = '0;
    logic [31:0] oData_RdData;
    logic        oTx;

    int n_checks = 0;
    int n_pass   = 0;

    data_bus_uart_tx #(
        .CLK_FREQ  (100),
        .BAUD      (10),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iSel        (iSel),
        .iFunct3     (iFunct3),
        .iData_WrEn  (iData_WrEn),
        .iData_Addr  (iData_Addr),
        .iData_WrData(iData_WrData),
        .oData_RdData(oData_RdData),
        .oTx         (oTx)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of pending bytes plus a frame timeline.
    // A frame popped at edge S with divisor D puts bit floor((E-S)/D) of
    // {stop, data[7:0], start} on the line after edge E, for 10*D edges.
    // ------------------------------------------------------------------
    byte unsigned m_q[$];
    bit           m_ovf    = 1'b0;
    int unsigned  m_div    = RST_DIV;
    int unsigned  m_divact = RST_DIV;
    bit           m_active = 1'b0;
    logic [7:0]   m_byte   = '0;
    longint       m_edge   = 0;
    longint       m_start  = 0;

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            m_q.delete();
            m_ovf    = 1'b0;
            m_div    = RST_DIV;
            m_active = 1'b0;
        end else begin
            int unsigned pre;
            int unsigned old_div;
            bit          pop;
            bit          wr;
            m_edge++;
            pre     = m_q.size();
            old_div = m_div;
            wr      = iSel && iData_WrEn;
            pop     = 1'b0;
            if (!m_active) begin
                pop = (pre > 0);
            end else if (m_edge - m_start == 10 * longint'(m_divact)) begin
                m_active = 1'b0;
                pop      = (pre > 0);
            end
            if (pop) begin
                m_byte   = m_q.pop_front();
                m_divact = old_div;
                m_start  = m_edge;
                m_active = 1'b1;
            end
            if (wr) begin
                case (iData_Addr[3:2])
                    2'd0: begin
                        if (pre < DEPTH || pop) m_q.push_back(iData_WrData[7:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd1: if (iData_WrData[3]) m_ovf = 1'b0;
                    2'd2: begin
                        logic [15:0] v;
                        v = m_div[15:0];
                        if (iFunct3[1:0] == 2'b00) begin
                            if (iData_Addr[1:0] == 2'd0) v[7:0] = iData_WrData[7:0];
                            if (iData_Addr[1:0] == 2'd1) v[15:8] = iData_WrData[7:0];
                        end else if (iFunct3[1:0] == 2'b01) begin
                            if (!iData_Addr[1]) v = iData_WrData[15:0];
                        end else begin
                            v = iData_WrData[15:0];
                        end
                        m_div = (v < 2) ? 2 : int'(v);
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic exp_tx();
        longint idx;
        if (!m_active) return 1'b1;
        idx = (m_edge - m_start) / longint'(m_divact);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[int'(idx) - 1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_read(input logic sel, input logic [31:0] addr);
        int unsigned n;
        if (!sel) return '0;
        n = m_q.size();
        case (addr[3:2])
            2'd1: return {23'd0, 5'(n), m_ovf, (n == 0), (n == DEPTH), m_active};
            2'd2: return {16'd0, m_div[15:0]};
            default: return '0;
        endcase
    endfunction

    // Line check on every falling edge.
    always @(negedge iClk) begin
        check("otx", {31'd0, oTx}, {31'd0, exp_tx()});
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; all assume they start 2 ns after a rising edge.
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #2;
    endtask

    task automatic do_write(input logic sel, input logic [31:0] addr,
                            input logic [31:0] data, input logic [2:0] f3);
        iSel         = sel;
        iData_WrEn   = 1'b1;
        iData_Addr   = addr;
        iData_WrData = data;
        iFunct3      = f3;
        @(posedge iClk);
        #2;
        iSel         = 1'b0;
        iData_WrEn   = 1'b0;
        iData_Addr   = '0;
        iData_WrData = '0;
    endtask

    task automatic rd(input logic sel, input logic [31:0] addr,
                      input logic [31:0] exp, input string name);
        iSel       = sel;
        iData_WrEn = 1'b0;
        iData_Addr = addr;
        #1;
        check(name, oData_RdData, exp);
        iSel       = 1'b0;
        iData_Addr = '0;
    endtask

    // Called right after the TXDATA write into an idle, empty, DIV=4 block.
    task automatic check_frame(input logic [7:0] b);
        logic [9:0] pat;
        pat = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            idle((i == 0) ? 1 : 4);
            check("frame_bit", {31'd0, oTx}, {31'd0, pat[i]});
            rd(1'b1, 32'h4, 32'h5, "frame_busy");
        end
        idle(4);
        rd(1'b1, 32'h4, 32'h4, "frame_done");
    endtask

    initial begin
        logic [7:0] b2b [5];
        b2b[0] = 8'hA5; b2b[1] = 8'h3C; b2b[2] = 8'hFF; b2b[3] = 8'h00; b2b[4] = 8'h81;

        #1 iRst = 1'b1;
        #1 check("rst_tx", {31'd0, oTx}, 32'd1);
        repeat (2) @(posedge iClk);
        #2 iRst = 1'b0;

        rd(1'b0, 32'h4, 32'h0, "nosel");
        rd(1'b1, 32'h4, 32'h4, "rst_status");
        rd(1'b1, 32'h8, 32'd10, "rst_div");
        rd(1'b1, 32'hC, 32'h0, "off_c");
        rd(1'b1, 32'h0, 32'h0, "txdata_rd");

        // Single frame 0x55 at DIV=4
        do_write(1'b1, 32'h8, 32'd4, 3'd2);
        rd(1'b1, 32'h8, 32'd4, "div4");
        do_write(1'b1, 32'h0, 32'hABCD_EF55, 3'd0);
        check_frame(8'h55);

        // Back-to-back bytes
        for (int i = 0; i < 5; i++) do_write(1'b1, 32'h0, {24'd0, b2b[i]}, 3'd0);
        rd(1'b1, 32'h4, 32'h43, "b2b_peak");
        idle(196);
        rd(1'b1, 32'h4, 32'h5, "b2b_busy");
        idle(1);
        rd(1'b1, 32'h4, 32'h4, "b2b_done");

        // Overflow
        do_write(1'b1, 32'h0, 32'h11, 3'd0);
        idle(2);
        for (int i = 0; i < 4; i++) do_write(1'b1, 32'h0, 32'h21 + i, 3'd0);
        rd(1'b1, 32'h4, 32'h43, "ovf_full");
        do_write(1'b1, 32'h0, 32'h77, 3'd0);
        rd(1'b1, 32'h4, 32'h4B, "ovf_set");
        do_write(1'b1, 32'h4, 32'h8, 3'd2);
        rd(1'b1, 32'h4, 32'h43, "ovf_clr");
        idle(250);
        rd(1'b1, 32'h4, 32'h4, "ovf_drain");

        // Baud register
        do_write(1'b1, 32'h8, 32'd0, 3'd2);
        rd(1'b1, 32'h8, 32'd2, "div_clamp");
        do_write(1'b1, 32'h8, 32'h1234, 3'd1);
        rd(1'b1, 32'h8, 32'h1234, "div_sh");
        do_write(1'b1, 32'h8, 32'd4, 3'd2);

        // Divisor change mid-frame: 40 cycles then 60 cycles
        do_write(1'b1, 32'h0, 32'h5A, 3'd0);
        idle(3);
        do_write(1'b1, 32'h8, 32'd6, 3'd2);
        rd(1'b1, 32'h8, 32'd6, "div_mid");
        do_write(1'b1, 32'h0, 32'hC3, 3'd0);
        idle(95);
        rd(1'b1, 32'h4, 32'h5, "divchg_busy");
        idle(1);
        rd(1'b1, 32'h4, 32'h4, "divchg_done");

        // Reset during data bits
        do_write(1'b1, 32'h8, 32'd4, 3'd2);
        do_write(1'b1, 32'h0, 32'h0F, 3'd0);
        idle(20);
        iRst = 1'b1;
        #1 check("rst_mid_tx", {31'd0, oTx}, 32'd1);
        rd(1'b1, 32'h4, 32'h4, "rst_mid_status");
        idle(2);
        iRst = 1'b0;
        rd(1'b1, 32'h8, 32'd10, "rst_mid_div");
        idle(60);
        rd(1'b1, 32'h4, 32'h4, "rst_mid_quiet");

        // SW to TXDATA sends only the low byte
        do_write(1'b1, 32'h8, 32'd4, 3'd2);
        do_write(1'b1, 32'h0, 32'h1234_5641, 3'd2);
        check_frame(8'h41);

        // Randomised traffic against the model
        for (int it = 0; it < 300; it++) begin
            int unsigned r;
            int unsigned g;
            logic [31:0] a;
            r = $urandom_range(0, 99);
            if (r < 45) begin
                a = $urandom & ~32'hC;
                do_write(1'b1, a, $urandom, 3'($urandom_range(0, 2)));
            end else if (r < 55) begin
                do_write(1'b1, 32'h8, $urandom_range(0, 5), 3'd2);
            end else if (r < 60) begin
                do_write(1'b1, 32'h4, $urandom, 3'd2);
            end else if (r < 65) begin
                do_write(1'b0, $urandom & ~32'hC, $urandom, 3'd0);
            end else if (r < 70) begin
                do_write(1'b1, 32'hC, $urandom, 3'd2);
            end else begin
                logic s;
                s = ($urandom_range(0, 3) != 0);
                a = $urandom;
                rd(s, a, model_read(s, a), "rand_rd");
            end
            g = $urandom_range(0, 3);
            if (g > 0) idle(int'(g));
        end
        idle(400);
        rd(1'b1, 32'h4, model_read(1'b1, 32'h4), "rand_drain");
        rd(1'b1, 32'h8, model_read(1'b1, 32'h8), "rand_div");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_bus_uart_tx.md
# data_bus_uart_tx

Memory-mapped UART transmitter that responds on the CPU data-memory port, the same store/load interface the core drives toward the data RAM: write enable, address, write data, funct3, and combinational read data. The core stores bytes into a transmit register; the block buffers them in a small FIFO and serialises them 8N1, LSB first, on a single output pin. An external address decoder asserts `iSel` for this block's window and muxes `oData_RdData` back to the core alongside the RAM.

## Interface

Parameters:

- `CLK_FREQ`, default 100_000_000. System clock frequency in Hz.
- `BAUD`, default 9600. Reset baud rate. The reset divisor is CLK_FREQ/BAUD, truncated, which is 10416 at the defaults.
- `FIFO_DEPTH`, default 4. Number of transmit FIFO entries. Must be a power of 2, range 2 to 16.

Ports:

- `iClk`, input, 1 bit. System clock; everything is on its rising edge.
- `iRst`, input, 1 bit. Reset, asynchronous and active-high.
- `iSel`, input, 1 bit. Block select from the address decoder.
- `iFunct3`, input, 3 bits. Access size from the load/store instruction.
- `iData_WrEn`, input, 1 bit. Store strobe.
- `iData_Addr`, input, 32 bits. Byte address. Only bits [3:2] are decoded.
- `iData_WrData`, input, 32 bits. Store data.
- `oData_RdData`, output, 32 bits. Combinational read data. Equals 0 when `iSel`=0.
- `oTx`, output, 1 bit. Serial line, registered. Idle level is high.

## Operation

Register map (word offsets, decoded from addr[3:2]):

- 0x0 TXDATA, write-only.
  - A store pushes `iData_WrData[7:0]`.
  - SB, SH and SW are all accepted; bits above [7:0] are ignored.
  - Reads return 0.
- 0x4 STATUS.
  - Read bit0: busy. Bit1: fifo_full. Bit2: fifo_empty. Bit3: overflow (sticky). Bits[8:4]: fifo count. All other bits read 0.
  - Write: a 1 in bit3 clears overflow. Writes to other bits are ignored.
- 0x8 BAUD_DIV.
  - Read/write, bits[15:0]; upper bits read 0.
  - Written values below 2 are stored as 2.
  - For SB/SH, only the addressed low byte or halfword lanes update, per addr[1:0].
- 0xC: reads 0, writes ignored.

Write decode and FIFO:

- A write occurs on the rising edge where `iSel` and `iData_WrEn` are both 1.
- A push is accepted if count < FIFO_DEPTH before the edge, or if the FSM pops on the same edge.
- If the FIFO is full and there is no simultaneous pop, the push is dropped and overflow is set to 1.
- Read and write pointers wrap modulo FIFO_DEPTH.

Transmit FSM, states IDLE, START, DATA, STOP:

- IDLE: `oTx`=1. If the FIFO is non-empty: pop into the shift register, latch BAUD_DIV into the active divisor, load bit counter=0, go to START.
- START: `oTx`=0 for DIV cycles, then go to DATA.
- DATA: `oTx`=shift[0]. Each DIV cycles, shift right and increment the bit counter. After bit 7 completes, go to STOP.
- STOP: `oTx`=1 for DIV cycles. At the end:
  - if the FIFO is non-empty, pop, relatch the divisor, go directly to START (no idle gap);
  - otherwise go to IDLE.
- busy = (state != IDLE).
- The baud counter counts 0 to DIV-1 and resets at each bit boundary.
- A BAUD_DIV write during a frame does not affect the current frame.

## Timing

- Reset values: `oTx`=1, state=IDLE, FIFO empty (count=0), overflow=0, BAUD_DIV=CLK_FREQ/BAUD truncated, `oData_RdData` combinational from the reset state.
- Reads are zero-wait combinational: STATUS reflects the register state before the current edge.
- Start-bit latency: a TXDATA write at edge N with the FSM idle and the FIFO empty gives count=1 after edge N. At edge N+1 the pop occurs and `oTx` goes to 0.
- Frame length: exactly 10×DIV cycles. `oTx` returns high at edge N+1+9×DIV.
- Back-to-back frames: the next start bit begins on the edge that ends the previous STOP bit.
- Push and pop on the same edge: count is unchanged and no overflow is flagged.
- Reset mid-frame: `oTx` goes to 1 asynchronously; the FIFO and FSM clear; the partial frame is aborted.

## Test plan

- Reset, then set BAUD_DIV=4 and store SB 0x55 to TXDATA → `oTx` reads 0,1,0,1,0,1,0,1,0,1 (start bit, LSB first, stop bit) at 4 cycles per bit; the frame is 40 cycles; busy=1 throughout, then 0.
- With DIV=4, store 0xA5, 0x3C, 0xFF, 0x00, 0x81 without waiting, with the FSM popping 0xA5 one cycle after its store → all five bytes are sent back-to-back with no idle gap; overflow stays 0; STATUS count peaks at 4.
- With DIV=4 and the FSM busy, fill the FIFO to 4 entries, then push 0x77 with no concurrent pop → 0x77 is never transmitted; overflow=1; a STATUS write of 0x8 clears it.
- Write BAUD_DIV=0 → it reads back 2. Write SH 0x1234 at offset 0x8 → it reads back 0x1234. Change DIV mid-frame → the current frame keeps the old bit width and the next frame uses the new one.
- Assert `iRst` halfway through the data bits of 0x0F → `oTx`=1 immediately; STATUS reads 0x4 (empty); no further bits are sent.
- Read with `iSel`=0 → `oData_RdData`=0. A read at offset 0xC returns 0. An SW of 0x12345641 to TXDATA → transmits 0x41.
